// File: rtl/goldminer_pkg.sv
// Shared widths, FSM state encodings and the nonce-insertion helper for the
// goldminer nonce-sweep datapath.
package goldminer_pkg;

  localparam int HASH_W  = 256;
  localparam int BLOCK_W = 512;
  localparam int NONCE_W = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_WAIT   = 3'd2;
  localparam state_t ST_CHECK  = 3'd3;
  localparam state_t ST_REPORT = 3'd4;

  // Word i of the block occupies bits [32i+31:32i].
  function automatic logic [BLOCK_W-1:0] insert_nonce(
    input logic [BLOCK_W-1:0] blk,
    input logic [NONCE_W-1:0] nonce,
    input int unsigned        word
  );
    logic [BLOCK_W-1:0] r;
    r = blk;
    r[NONCE_W*word +: NONCE_W] = nonce;
    return r;
  endfunction

endpackage

// File: rtl/hash_target_cmp.sv
// Combinational 256-bit unsigned hash < target compare, kept separate so it
// can be pipelined without touching the sweep controller.
module hash_target_cmp
  import goldminer_pkg::*;
(
  input  logic [HASH_W-1:0] hash,
  input  logic [HASH_W-1:0] target,
  output logic              less
);

  assign less = (hash < target);

endmodule

// File: rtl/mining_sched.sv
// Nonce-sweep controller: hashes template+nonce on an external SHA-256 core
// for each nonce in an inclusive, wrapping range and reports the first hit.
module mining_sched
  import goldminer_pkg::*;
#(
  parameter int NONCE_WORD     = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [BLOCK_W-1:0]  cfg_template,
  input  logic [NONCE_W-1:0]  cfg_nonce_start,
  input  logic [NONCE_W-1:0]  cfg_nonce_end,
  input  logic [HASH_W-1:0]   cfg_target,
  input  logic                abort,
  output logic                sha_start,
  output logic [BLOCK_W-1:0]  sha_data_in,
  input  logic                sha_done,
  input  logic [HASH_W-1:0]   sha_data_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                res_found,
  output logic [NONCE_W-1:0]  res_nonce,
  output logic [HASH_W-1:0]   res_hash,
  output logic                busy,
  output logic                timeout_err,
  output logic [31:0]         hash_count
);

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t               state;
  logic [BLOCK_W-1:0]   tmpl_q;
  logic [NONCE_W-1:0]   nonce_q;
  logic [NONCE_W-1:0]   nonce_end_q;
  logic [HASH_W-1:0]    target_q;
  logic [15:0]          wd_cnt;
  logic                 hash_lt;
  logic                 accept;
  logic                 last_nonce;
  logic                 advance;
  logic [NONCE_W-1:0]   nonce_next;

  assign cfg_ready  = reset_n && (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign accept     = cfg_ready && cfg_valid;
  assign last_nonce = (nonce_q == nonce_end_q);
  assign nonce_next = nonce_q + 32'd1;
  assign advance    = (state == ST_CHECK) && !abort && !hash_lt && !last_nonce;

  // res_hash doubles as the digest capture register; it is only compared in CHECK.
  hash_target_cmp u_cmp (
    .hash   (res_hash),
    .target (target_q),
    .less   (hash_lt)
  );

  // Job parameters: frozen between accept and return to IDLE.
  always_ff @(posedge clk) begin
    if (accept) begin
      tmpl_q      <= cfg_template;
      nonce_end_q <= cfg_nonce_end;
      target_q    <= cfg_target;
      nonce_q     <= cfg_nonce_start;
    end else if (advance) begin
      nonce_q <= nonce_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      sha_start   <= 1'b0;
      sha_data_in <= '0;
      res_valid   <= 1'b0;
      res_found   <= 1'b0;
      res_nonce   <= '0;
      res_hash    <= '0;
      timeout_err <= 1'b0;
      hash_count  <= '0;
      wd_cnt      <= '0;
    end else begin
      sha_start <= 1'b0;
      if (state != ST_IDLE && abort) begin
        state     <= ST_IDLE;
        res_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              sha_data_in <= insert_nonce(cfg_template, cfg_nonce_start, NONCE_WORD);
              sha_start   <= 1'b1;
              hash_count  <= '0;
              timeout_err <= 1'b0;
              state       <= ST_START;
            end
          end
          ST_START: begin
            wd_cnt <= '0;
            state  <= ST_WAIT;
          end
          ST_WAIT: begin
            // wd_cnt == 0 marks the first WAIT cycle, where done may be stale.
            if (sha_done && wd_cnt != 16'd0) begin
              res_hash   <= sha_data_out;
              hash_count <= sat_inc(hash_count);
              state      <= ST_CHECK;
            end else if (wd_cnt == WD_LAST) begin
              timeout_err <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              wd_cnt <= wd_cnt + 16'd1;
            end
          end
          ST_CHECK: begin
            if (hash_lt || last_nonce) begin
              res_found <= hash_lt;
              res_nonce <= nonce_q;
              res_valid <= 1'b1;
              state     <= ST_REPORT;
            end else begin
              sha_data_in <= insert_nonce(tmpl_q, nonce_next, NONCE_WORD);
              sha_start   <= 1'b1;
              state       <= ST_START;
            end
          end
          ST_REPORT: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              state     <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mining_sched.sv
// Directed bench for mining_sched with a behavioural SHA core stand-in.
module tb_mining_sched;
  localparam logic [511:0] KNOWN_BLK = {32'h000001BF, 32'h0, 32'h1, 320'h0,
                                        32'h39300000, 32'h35363738, 32'h31323334};
  localparam logic [255:0] KNOWN_HASH =
    256'h7d12643bec5c8e5b07fda92f1c07e5f2dda528048200d86def89af1ec22d9f0d;

  logic         clk = 0;
  logic         reset_n = 0;
  logic         cfg_valid = 0;
  logic         cfg_ready;
  logic [511:0] cfg_template = '0;
  logic [31:0]  cfg_nonce_start = '0;
  logic [31:0]  cfg_nonce_end = '0;
  logic [255:0] cfg_target = '0;
  logic         abort = 0;
  logic         sha_start;
  logic [511:0] sha_data_in;
  logic         sha_done;
  logic [255:0] sha_data_out;
  logic         res_valid;
  logic         res_ready = 0;
  logic         res_found;
  logic [31:0]  res_nonce;
  logic [255:0] res_hash;
  logic         busy;
  logic         timeout_err;
  logic [31:0]  hash_count;

  int checks = 0;
  int failures = 0;

  // Core model: 0 = digest is nonce zero-extended, 1 = known vector, 2 = never done.
  int           core_mode = 0;
  logic         force_done = 0;
  logic         core_done = 0;
  logic [255:0] core_dout = '0;
  int           core_cnt = 0;
  int           start_total = 0;
  int           wide_total = 0;
  int           rv_total = 0;
  logic         prev_start = 0;

  assign sha_done = core_done | force_done;

  always #5 clk = ~clk;

  mining_sched #(.NONCE_WORD(0), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_template(cfg_template), .cfg_nonce_start(cfg_nonce_start),
    .cfg_nonce_end(cfg_nonce_end), .cfg_target(cfg_target), .abort(abort),
    .sha_start(sha_start), .sha_data_in(sha_data_in), .sha_done(sha_done),
    .sha_data_out(sha_data_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_found(res_found), .res_nonce(res_nonce), .res_hash(res_hash),
    .busy(busy), .timeout_err(timeout_err), .hash_count(hash_count)
  );

  assign sha_data_out = core_dout;

  always @(posedge clk) begin
    if (sha_start) begin
      core_cnt  <= 4;
      core_done <= 1'b0;
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end else if (core_cnt == 1) begin
      core_cnt <= 0;
      if (core_mode != 2) begin
        core_done <= 1'b1;
        if (core_mode == 1)
          core_dout <= (sha_data_in == KNOWN_BLK) ? KNOWN_HASH : '1;
        else
          core_dout <= {224'd0, sha_data_in[31:0]};
      end
    end else begin
      core_done <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (sha_start) start_total <= start_total + 1;
    if (sha_start && prev_start) wide_total <= wide_total + 1;
    if (res_valid) rv_total <= rv_total + 1;
    prev_start <= sha_start;
  end

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [511:0] t, input logic [31:0] s,
                           input logic [31:0] e, input logic [255:0] tg);
    cfg_template    = t;
    cfg_nonce_start = s;
    cfg_nonce_end   = e;
    cfg_target      = tg;
    cfg_valid       = 1;
    tick();
    cfg_valid = 0;
  endtask

  task automatic wait_res(input int max, output int n);
    n = 0;
    while (!res_valid && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic ack();
    res_ready = 1;
    tick();
    res_ready = 0;
  endtask

  initial begin
    int n;
    int s0;
    int w0;
    int r0;

    // Reset values
    tick(); tick();
    check_eq("rst_cfg_ready", 512'(cfg_ready), 512'd0);
    check_eq("rst_busy", 512'(busy), 512'd0);
    check_eq("rst_sha_start", 512'(sha_start), 512'd0);
    check_eq("rst_res_valid", 512'(res_valid), 512'd0);
    check_eq("rst_tmo", 512'(timeout_err), 512'd0);
    check_eq("rst_count", 512'(hash_count), 512'd0);
    check_eq("rst_data_in", sha_data_in, 512'd0);
    reset_n = 1;
    tick();
    check_eq("rel_cfg_ready", 512'(cfg_ready), 512'd1);

    // Known vector: hit
    core_mode = 1;
    start_job(KNOWN_BLK, 32'h31323334, 32'h31323334, '1);
    check_eq("kv_start", 512'(sha_start), 512'd1);
    check_eq("kv_busy", 512'(busy), 512'd1);
    check_eq("kv_data_in", sha_data_in, KNOWN_BLK);
    wait_res(50, n);
    check_eq("kv_latency", 512'(n), 512'd7);
    check_eq("kv_found", 512'(res_found), 512'd1);
    check_eq("kv_nonce", 512'(res_nonce), 512'h31323334);
    check_eq("kv_hash", 512'(res_hash), 512'(KNOWN_HASH));
    check_eq("kv_count", 512'(hash_count), 512'd1);
    ack();
    check_eq("kv_idle", 512'(busy), 512'd0);
    check_eq("kv_rv_drop", 512'(res_valid), 512'd0);

    // Exhaustion
    start_job(KNOWN_BLK, 32'h31323334, 32'h31323334, '0);
    wait_res(50, n);
    check_eq("ex_valid", 512'(res_valid), 512'd1);
    check_eq("ex_found", 512'(res_found), 512'd0);
    check_eq("ex_nonce", 512'(res_nonce), 512'h31323334);
    check_eq("ex_count", 512'(hash_count), 512'd1);
    ack();

    // Wrap and hit, then backpressure
    core_mode = 0;
    s0 = start_total;
    w0 = wide_total;
    start_job(KNOWN_BLK, 32'hFFFFFFFE, 32'd3, 256'd2);
    check_eq("wr_data_in", sha_data_in, {KNOWN_BLK[511:32], 32'hFFFFFFFE});
    wait_res(100, n);
    check_eq("wr_latency", 512'(n), 512'd21);
    check_eq("wr_found", 512'(res_found), 512'd1);
    check_eq("wr_nonce", 512'(res_nonce), 512'd0);
    check_eq("wr_hash", 512'(res_hash), 512'd0);
    check_eq("wr_count", 512'(hash_count), 512'd3);
    check_eq("wr_starts", 512'(start_total - s0), 512'd3);
    check_eq("wr_wide", 512'(wide_total - w0), 512'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp_valid", 512'(res_valid), 512'd1);
      check_eq("bp_nonce", 512'(res_nonce), 512'd0);
    end
    ack();
    check_eq("bp_idle", 512'(busy), 512'd0);

    // Abort in WAIT
    r0 = rv_total;
    start_job(KNOWN_BLK, 32'd10, 32'd20, '0);
    tick();
    check_eq("ab_in_wait", 512'(busy), 512'd1);
    abort = 1;
    tick();
    abort = 0;
    check_eq("ab_busy", 512'(busy), 512'd0);
    check_eq("ab_start", 512'(sha_start), 512'd0);
    tick(); tick(); tick(); tick(); tick(); tick();
    check_eq("ab_no_result", 512'(rv_total - r0), 512'd0);

    // abort with cfg_valid in IDLE accepts the job
    abort = 1;
    start_job(KNOWN_BLK, 32'd5, 32'd5, 256'd6);
    abort = 0;
    check_eq("ac_busy", 512'(busy), 512'd1);
    check_eq("ac_start", 512'(sha_start), 512'd1);
    wait_res(50, n);
    check_eq("ac_found", 512'(res_found), 512'd1);
    check_eq("ac_hash", 512'(res_hash), 512'd5);
    ack();

    // Watchdog timeout
    core_mode = 2;
    r0 = rv_total;
    start_job(KNOWN_BLK, 32'd1, 32'd9, '0);
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check_eq("to_cycles", 512'(n), 512'd9);
    check_eq("to_err", 512'(timeout_err), 512'd1);
    check_eq("to_busy", 512'(busy), 512'd0);
    check_eq("to_no_result", 512'(rv_total - r0), 512'd0);
    core_mode = 0;
    start_job(KNOWN_BLK, 32'd7, 32'd7, '0);
    check_eq("to_cleared", 512'(timeout_err), 512'd0);
    wait_res(50, n);
    check_eq("to_next_nonce", 512'(res_nonce), 512'd7);
    ack();

    // Stale done held high: capture only in the second WAIT cycle
    force_done = 1;
    start_job(KNOWN_BLK, 32'd100, 32'd100, '0);
    tick();
    check_eq("sd_wait1_count", 512'(hash_count), 512'd0);
    tick();
    check_eq("sd_wait2_count", 512'(hash_count), 512'd0);
    tick();
    check_eq("sd_capture", 512'(hash_count), 512'd1);
    wait_res(10, n);
    check_eq("sd_latency", 512'(n), 512'd1);
    check_eq("sd_nonce", 512'(res_nonce), 512'd100);
    force_done = 0;
    ack();

    // Reset mid-WAIT
    start_job(KNOWN_BLK, 32'd1, 32'd50, '0);
    tick();
    check_eq("mr_busy", 512'(busy), 512'd1);
    reset_n = 0;
    tick();
    check_eq("mr_busy0", 512'(busy), 512'd0);
    check_eq("mr_cfg_ready", 512'(cfg_ready), 512'd0);
    check_eq("mr_start", 512'(sha_start), 512'd0);
    check_eq("mr_valid", 512'(res_valid), 512'd0);
    check_eq("mr_found", 512'(res_found), 512'd0);
    check_eq("mr_nonce", 512'(res_nonce), 512'd0);
    check_eq("mr_hash", 512'(res_hash), 512'd0);
    check_eq("mr_count", 512'(hash_count), 512'd0);
    check_eq("mr_data_in", sha_data_in, 512'd0);
    reset_n = 1;
    tick();
    check_eq("mr_ready", 512'(cfg_ready), 512'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mining_sched.md
# mining_sched

Nonce-sweep controller that sequences the single-block `sha256_module` core in the goldminer datapath. It accepts a 512-bit message template, an inclusive nonce range and a 256-bit difficulty target. For each nonce it inserts the nonce into the template, runs one hash on the core, and compares the digest against the target. It stops and reports on the first hit, on range exhaustion, or on abort, and includes a done-watchdog on the core.

## Interface
- `NONCE_WORD`, 3: index of the 32-bit template word replaced by the nonce; word i = bits [32i+31:32i].
- `TIMEOUT_CYCLES`, 255: maximum WAIT cycles without `sha_done` before the timeout fires; legal range 2..65535.
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `cfg_valid`  in  1  job request.
- `cfg_ready`  out  1  high in IDLE only.
- `cfg_template`  in  512  message block; padding is already applied.
- `cfg_nonce_start`  in  32  first nonce.
- `cfg_nonce_end`  in  32  last nonce, inclusive.
- `cfg_target`  in  256  unsigned target; a hit requires hash < target.
- `abort`  in  1  cancel the current job.
- `sha_start`  out  1  one-cycle start pulse to the core.
- `sha_data_in`  out  512  core input block.
- `sha_done`  in  1  core completion; level or pulse.
- `sha_data_out`  in  256  core digest; bit 255 is the MSB.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed.
- `res_found`  out  1  1 = hit, 0 = range exhausted.
- `res_nonce`  out  32  hit nonce, or `cfg_nonce_end` when exhausted.
- `res_hash`  out  256  digest of `res_nonce`.
- `busy`  out  1  high in any state other than IDLE.
- `timeout_err`  out  1  sticky watchdog flag.
- `hash_count`  out  32  digests captured this job; saturating.

## Operation

**States:** IDLE, START, WAIT, CHECK, REPORT.

- **IDLE**
  - `cfg_valid & cfg_ready` latches template, range and target.
  - Sets nonce = `cfg_nonce_start`.
  - Clears `hash_count` and `timeout_err`.
  - Next state: START.
- **START**
  - `sha_data_in` = template with word `NONCE_WORD` replaced by nonce.
  - `sha_start`=1 for this cycle only.
  - Next state: WAIT.
- **WAIT**
  - `sha_data_in` is held stable.
  - `sha_done` is ignored in the first WAIT cycle (stale level from the previous run); it is sampled from the second cycle on.
  - On `sha_done`: capture `sha_data_out` into the hash register, `hash_count`+1 (saturates at 0xFFFFFFFF), next state CHECK.
  - Watchdog counts WAIT cycles. On reaching `TIMEOUT_CYCLES` without `sha_done`: `timeout_err`=1, next state IDLE, no result.
- **CHECK** (one cycle), in priority order:
  - hash < target (256-bit unsigned): REPORT with found=1.
  - Else nonce == `nonce_end`: REPORT with found=0.
  - Else nonce = nonce+1 mod 2^32, next state START.
  - The range wraps: start=0xFFFFFFFE, end=1 yields 4 hashes.
- **REPORT**
  - `res_valid`=1, with `res_*` stable, until `res_ready` is high.
  - The handshake cycle returns to IDLE.
- **abort**
  - In any non-IDLE state, abort forces IDLE on the next edge.
  - `res_valid` and `sha_start` drop, and no result is produced.
  - abort in IDLE is ignored; `cfg_valid` and `abort` in the same IDLE cycle accepts the job.
- Template, range and target are frozen while `busy`=1.

## Timing
- **Reset values:** state IDLE; `sha_start`, `res_valid`, `res_found`, `busy`, `timeout_err` = 0; `sha_data_in`, `res_nonce`, `res_hash`, `hash_count` = 0. `cfg_ready` = 0 while `reset_n`=0, and 1 from the first cycle after reset release.
- **Reset mid-job:** identical to reset at power-up; the core is not flushed and its stale `done` is masked by the first-WAIT rule.
- **Cycle sequence:**
  - Config handshake at edge 0.
  - `sha_start` high in cycle 1.
  - `sha_done` is first honoured in cycle 3.
  - If the core raises done in cycle D, CHECK runs in cycle D+1.
  - The next START (on a miss) is in cycle D+2; REPORT begins in cycle D+2.
  - Per-nonce cost is (D − start cycle) + 2 cycles.
- **Outputs:** all are registered except `cfg_ready` and `busy` (state decode).

## Structure
- **`goldminer_pkg`:** state enum, `HASH_W`=256, `BLOCK_W`=512, `NONCE_W`=32, and the word-insert function.
- **`hash_target_cmp`:** natural sub-module; combinational 256-bit unsigned less-than, isolated so it can later be pipelined.
- Top level: FSM, nonce counter, watchdog, result registers. Instantiation of the core is done by the parent.

## Test plan
- **Known vector:** `NONCE_WORD`=0, template = {0x000001BF, 0, 1, 320×0, 0x39300000, 0x35363738, 0x31323334}, start = end = 0x31323334, target = all-ones, real core → `res_found`=1, `res_nonce`=0x31323334, `res_hash`=7d12643bec5c8e5b07fda92f1c07e5f2dda528048200d86def89af1ec22d9f0d, `hash_count`=1.
- **Exhaustion:** same vector with target=0 → `res_found`=0, `res_nonce`=0x31323334, `hash_count`=1.
- **Wrap and hit:** behavioural core returning digest = nonce zero-extended, done 5 cycles after start; start=0xFFFFFFFE, end=3, target=2 → hit at nonce 0 after 3 hashes, `sha_start` pulses exactly 3 times, each one cycle wide.
- **Backpressure and abort:**
  - `res_ready` low for 10 cycles → `res_*` stable; release → IDLE.
  - A second job aborted in WAIT → IDLE next cycle with no `res_valid`.
  - `abort` together with `cfg_valid` in IDLE → job accepted.
- **Timeout:** `TIMEOUT_CYCLES`=8, core never asserts done → `timeout_err`=1, `busy`=0, no result; the next cfg accept clears `timeout_err`.
- **Stale done:** `sha_done` held high continuously from the previous run → first WAIT cycle ignored, capture in the second WAIT cycle; `reset_n` low mid-WAIT → all outputs at reset values the following cycle.
